seq_player: RTL
===============

# seq_player

Playback controller for the Genius LED path. On a start pulse it walks the stored game sequence from index 0 to len-1 and drives the LED driver's enable/color inputs with an on/off cadence derived from the speed switch, then returns a one-cycle done pulse. It sits between the game FSM (which owns the sequence memory and issues start/abort) and led_driver, replacing inline show-LED sequencing.

## Interface
- MAX_LEN, 32: maximum sequence length (sequence memory depth).
- IDX_W, 5: index width, $clog2(MAX_LEN).
- LEN_W, 6: length width, $clog2(MAX_LEN+1).
- TICK, 12_500_000: clock cycles per timing unit; must be ≥ 2.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin playback; sampled only in IDLE.
- abort  in  1  terminate playback; highest priority.
- len  in  LEN_W  number of elements to play; latched at start; values > MAX_LEN are clamped to MAX_LEN.
- speed  in  velocity_t  cadence select; latched at start.
- rd_idx  out  IDX_W  sequence memory read address.
- rd_color  in  color_t  asynchronous-read data for rd_idx, valid in the same cycle.
- led_enable  out  1  to led_driver enable.
- led_color  out  color_t  to led_driver color.
- busy  out  1  playback in progress.
- done  out  1  one-cycle pulse on normal completion.

## Operation
- States: IDLE, LEAD, ON, OFF, DONE.
- Durations (in cycles, from the latched speed):
  - SLOW: N_on = 4·TICK.
  - NORMAL: N_on = 2·TICK.
  - FAST: N_on = TICK.
  - Any other encoding is treated as NORMAL.
  - N_off = N_on/2 in all cases.
- IDLE: on start with abort=0, latch len and speed, set rd_idx=0.
  - len==0: go to DONE.
  - Otherwise: go to LEAD and load the timer with N_off.
- LEAD: LEDs off for N_off cycles. On expiry, capture rd_color into led_color and go to ON (timer loaded with N_on).
- ON: led_enable=1 for exactly N_on cycles, then go to OFF (timer loaded with N_off).
- OFF: led_enable=0 for N_off cycles. On expiry:
  - If rd_idx == len-1: go to DONE.
  - Otherwise: rd_idx+1, capture the new element's rd_color, go to ON.
- DONE: one cycle with done=1, then go to IDLE. rd_idx holds its last value until the next start.
- abort in any non-IDLE state: go to IDLE the next cycle, led_enable=0, rd_idx=0, no done pulse. Abort beats timer expiry.
- abort and start together in IDLE: start is ignored.
- start while not in IDLE: ignored.
- Changes to speed or len during playback: no effect.

## Timing
- Reset values:
  - led_enable=0, led_color=COLOR_RED, busy=0, done=0, rd_idx=0.
  - State=IDLE, timer=0.
- Reset mid-operation: all outputs take their reset values immediately (asynchronous).
- busy=1 in LEAD/ON/OFF and 0 in IDLE/DONE.
- Total latency, start-sample edge to done pulse: 1 + N_off + len·(N_on+N_off) cycles.
- len==0: done is asserted in the cycle right after start is sampled.
- led_color changes only on entry to ON. It holds its value through OFF, DONE and IDLE.
- rd_color must be stable in the cycle in which LEAD or OFF expires.
- All outputs are registered.

## Configuration
- SEQ_PLAYER_LAST_ONLY_EN defined:
  - Adds input port last_only (1 bit), latched at start.
  - When last_only=1 and len>0, rd_idx starts at len-1 and exactly one element is played. Used for the add-color echo in the "Mando eu" mode.
- Not defined: the port is absent and the full sequence is always played.

## Structure
- Shared package (typedefs):
  - color_t and velocity_t (already present).
  - New seq_state_t enum: SEQ_IDLE, SEQ_LEAD, SEQ_ON, SEQ_OFF, SEQ_DONE.
  - Speed multiplier constants: SPD_MULT_SLOW=4, SPD_MULT_NORMAL=2, SPD_MULT_FAST=1.
- One sub-module, seq_timer: loadable down-counter of width $clog2(4·TICK+1), with load/value inputs and an expire flag asserted when the count reaches 1.

## Test plan
All scenarios use TICK=4, giving NORMAL 8/4 and FAST 4/2.
- len=3, NORMAL, memory R,G,B, start at edge 0:
  - led_enable high in cycles 5–12 (R), 17–24 (G) and 29–36 (B).
  - busy high in cycles 1–40; done in cycle 41 only.
- len=0, start: done in cycle 1, busy never asserted, led_enable stays 0.
- len=4, NORMAL, abort in the 3rd cycle of element 2's ON:
  - Next cycle: led_enable=0, busy=0, rd_idx=0.
  - done is never asserted.
- len=2, FAST, speed switched to SLOW mid-run: ON windows stay 4 cycles and gaps 2 cycles; done at cycle 1+2+2·6 = 15.
- start pulsed again while busy → ignored. len=40 → clamped: exactly 32 ON windows, rd_idx reaches 31.
- rst_n low during ON:
  - led_enable, busy and rd_idx go to 0 immediately.
  - After release, no activity until the next start.

Source files
------------

// File: rtl/seq_player_pkg.sv
// Shared types for the Genius LED playback path: colors, speed select, playback states
// and the speed-to-duration mapping.
package seq_player_pkg;

   typedef enum logic [1:0] {
      COLOR_RED    = 2'd0,
      COLOR_GREEN  = 2'd1,
      COLOR_BLUE   = 2'd2,
      COLOR_YELLOW = 2'd3
   } color_t;

   typedef enum logic [1:0] {
      VEL_SLOW   = 2'd0,
      VEL_NORMAL = 2'd1,
      VEL_FAST   = 2'd2
   } velocity_t;

   typedef enum logic [2:0] {
      SEQ_IDLE = 3'd0,
      SEQ_LEAD = 3'd1,
      SEQ_ON   = 3'd2,
      SEQ_OFF  = 3'd3,
      SEQ_DONE = 3'd4
   } seq_state_t;

   localparam int unsigned SPD_MULT_SLOW   = 4;
   localparam int unsigned SPD_MULT_NORMAL = 2;
   localparam int unsigned SPD_MULT_FAST   = 1;

   // LED-on duration in cycles; unknown encodings fall back to NORMAL.
   function automatic int unsigned dur_on(input velocity_t v, input int unsigned tick);
      int unsigned mult;
      case (v)
         VEL_SLOW: mult = SPD_MULT_SLOW;
         VEL_FAST: mult = SPD_MULT_FAST;
         default:  mult = SPD_MULT_NORMAL;
      endcase
      return mult * tick;
   endfunction

endpackage

// File: rtl/seq_player_timer.sv
// seq_timer: loadable down-counter; o_expire flags the last cycle of a loaded interval.
module seq_timer #(
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_expire
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_expire = (r_cnt == W'(1));

endmodule

// File: rtl/seq_player.sv
// Sequence playback controller driving led_driver with an on/off cadence.
// Optional feature macro: SEQ_PLAYER_LAST_ONLY_EN (adds i_last_only, plays only the last element).
module seq_player
   import seq_player_pkg::*;
#(
   parameter int unsigned MAX_LEN = 32,
   parameter int unsigned IDX_W   = $clog2(MAX_LEN),
   parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
   parameter int unsigned TICK    = 12_500_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [LEN_W-1:0] i_len,
   input  velocity_t        i_speed,
`ifdef SEQ_PLAYER_LAST_ONLY_EN
   input  logic             i_last_only,
`endif
   output logic [IDX_W-1:0] o_rd_idx,
   input  color_t           i_rd_color,
   output logic             o_led_enable,
   output color_t           o_led_color,
   output logic             o_busy,
   output logic             o_done
);

   localparam int unsigned TW = $clog2(4 * TICK + 1);

   seq_state_t       r_state, w_state_nxt;
   velocity_t        r_speed, w_speed_nxt;
   logic [IDX_W-1:0] r_last, w_last_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt;
   logic             r_last_played, w_last_played_nxt;
   logic             r_led_en, w_led_en_nxt;
   color_t           r_color, w_color_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;

   logic             w_load;
   logic [TW-1:0]    w_load_val;
   logic             w_expire;
   logic [LEN_W-1:0] w_len_clamp;
   logic [IDX_W-1:0] w_last_in;
   logic             w_last_only;
   logic [TW-1:0]    w_on_r, w_off_r, w_off_in;

`ifdef SEQ_PLAYER_LAST_ONLY_EN
   assign w_last_only = i_last_only;
`else
   assign w_last_only = 1'b0;
`endif

   assign w_len_clamp = (i_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_len;
   assign w_last_in   = IDX_W'(w_len_clamp - 1'b1);
   assign w_on_r      = TW'(dur_on(r_speed, TICK));
   assign w_off_r     = TW'(dur_on(r_speed, TICK) / 2);
   assign w_off_in    = TW'(dur_on(i_speed, TICK) / 2);

   seq_timer #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_value  (w_load_val),
      .o_expire (w_expire)
   );

   // rd_idx advances when ON ends, so the next element's color has settled by OFF expiry.
   always_comb begin
      w_state_nxt       = r_state;
      w_speed_nxt       = r_speed;
      w_last_nxt        = r_last;
      w_idx_nxt         = r_idx;
      w_last_played_nxt = r_last_played;
      w_led_en_nxt      = r_led_en;
      w_color_nxt       = r_color;
      w_load            = 1'b0;
      w_load_val        = '0;
      case (r_state)
         SEQ_IDLE: begin
            if (i_start && !i_abort) begin
               w_speed_nxt       = i_speed;
               w_last_nxt        = w_last_in;
               w_last_played_nxt = 1'b0;
               w_idx_nxt         = '0;
               if (w_len_clamp == '0) begin
                  w_state_nxt = SEQ_DONE;
               end else begin
                  if (w_last_only) w_idx_nxt = w_last_in;
                  w_state_nxt = SEQ_LEAD;
                  w_load      = 1'b1;
                  w_load_val  = w_off_in;
               end
            end
         end
         SEQ_LEAD: begin
            if (w_expire) begin
               w_color_nxt  = i_rd_color;
               w_led_en_nxt = 1'b1;
               w_state_nxt  = SEQ_ON;
               w_load       = 1'b1;
               w_load_val   = w_on_r;
            end
         end
         SEQ_ON: begin
            if (w_expire) begin
               w_led_en_nxt = 1'b0;
               w_state_nxt  = SEQ_OFF;
               w_load       = 1'b1;
               w_load_val   = w_off_r;
               if (r_idx == r_last) w_last_played_nxt = 1'b1;
               else                 w_idx_nxt = r_idx + 1'b1;
            end
         end
         SEQ_OFF: begin
            if (w_expire) begin
               if (r_last_played) begin
                  w_state_nxt = SEQ_DONE;
               end else begin
                  w_color_nxt  = i_rd_color;
                  w_led_en_nxt = 1'b1;
                  w_state_nxt  = SEQ_ON;
                  w_load       = 1'b1;
                  w_load_val   = w_on_r;
               end
            end
         end
         SEQ_DONE: w_state_nxt = SEQ_IDLE;
         default:  w_state_nxt = SEQ_IDLE;
      endcase

      if (i_abort && (r_state != SEQ_IDLE)) begin
         w_state_nxt  = SEQ_IDLE;
         w_led_en_nxt = 1'b0;
         w_idx_nxt    = '0;
         w_load       = 1'b1;
         w_load_val   = '0;
      end

      w_busy_nxt = (w_state_nxt == SEQ_LEAD) || (w_state_nxt == SEQ_ON) ||
                   (w_state_nxt == SEQ_OFF);
      w_done_nxt = (w_state_nxt == SEQ_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= SEQ_IDLE;
         r_speed       <= VEL_NORMAL;
         r_last        <= '0;
         r_idx         <= '0;
         r_last_played <= 1'b0;
         r_led_en      <= 1'b0;
         r_color       <= COLOR_RED;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_speed       <= w_speed_nxt;
         r_last        <= w_last_nxt;
         r_idx         <= w_idx_nxt;
         r_last_played <= w_last_played_nxt;
         r_led_en      <= w_led_en_nxt;
         r_color       <= w_color_nxt;
         r_busy        <= w_busy_nxt;
         r_done        <= w_done_nxt;
      end
   end

   assign o_rd_idx     = r_idx;
   assign o_led_enable = r_led_en;
   assign o_led_color  = r_color;
   assign o_busy       = r_busy;
   assign o_done       = r_done;

endmodule
